// File: rtl/stereo_pkg.sv
// ---------------------------------------------------------------------------
// stereo_pkg
// Shared width helpers and constants for the stereo matching blocks.
//   clog2()      : ceiling log2, usable in parameter expressions
//   disp_width() : bits needed to hold a disparity index 0..max_disp-1
//   cost_width() : bits needed to hold a Hamming cost 0..cw
//   max_cost()   : largest cost a cw-bit census pair can produce
// ---------------------------------------------------------------------------
package stereo_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = (value > 0) ? value - 1 : 0;
      while (span > 0) begin
         result++;
         span = span >> 1;
      end
      return result;
   endfunction

   function automatic int unsigned disp_width(input int unsigned max_disp);
      return clog2(max_disp);
   endfunction

   function automatic int unsigned cost_width(input int unsigned cw);
      return clog2(cw + 1);
   endfunction

   // Every bit of the two codes differs: the cost can never exceed cw.
   function automatic int unsigned max_cost(input int unsigned cw);
      return cw;
   endfunction

endpackage : stereo_pkg

// File: rtl/hamming_cost.sv
// ---------------------------------------------------------------------------
// hamming_cost
// Combinational Hamming distance between two census codes.
//   a_i    : first census code  (CW bits)
//   b_i    : second census code (CW bits)
//   cost_o : popcount(a_i ^ b_i) (HW bits, wide enough for CW, never wraps)
// ---------------------------------------------------------------------------
module hamming_cost
   import stereo_pkg::*;
#(
   parameter int unsigned CW = 8,
   parameter int unsigned HW = cost_width(CW)
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   output logic [HW-1:0] cost_o
);

   logic [CW-1:0] diff;
   logic [HW-1:0] sum;

   assign diff = a_i ^ b_i;

   always_comb begin
      // NOTE: sum is given a value before the loop, so every path assigns it and no latch is inferred.
      sum = '0;
      // NOTE: blocking assignments here, because each iteration must see the sum from the previous one.
      for (int i = 0; i < int'(CW); i++) begin
         sum = sum + HW'(diff[i]);
      end
   end

   assign cost_o = sum;

endmodule : hamming_cost

// File: rtl/stereo_wta_n.sv
// ---------------------------------------------------------------------------
// stereo_wta_n
// Census-transform stereo matcher with winner-take-all disparity selection.
// A right-code delay line offers MAX_DISP candidates per left pixel; each is
// scored by Hamming distance, and the cheapest eligible candidate wins.
// Two pipeline stages: costs+eligibility, then winner/uniqueness.
//   pxclk      : clock, all state on rising edge
//   reset      : synchronous, active-high
//   in_valid   : lCensus/rCensus carry a pixel
//   line_start : with in_valid, marks column 0
//   lCensus    : left census code
//   rCensus    : right census code
//   out_valid  : in_valid delayed by exactly two cycles
//   disparity  : winning disparity
//   cost       : Hamming cost of the winner
//   uniq       : winner passes the uniqueness test ("unique" is a reserved
//                word in SystemVerilog, hence the shortened name)
// Outputs hold their last values while out_valid is low.
// ---------------------------------------------------------------------------
module stereo_wta_n
   import stereo_pkg::*;
#(
   parameter  int unsigned CW       = 8,
   parameter  int unsigned MAX_DISP = 4,
   parameter  int unsigned UNIQ_TH  = 1,
   localparam int unsigned DW       = disp_width(MAX_DISP),
   localparam int unsigned HW       = cost_width(CW)
) (
   input  logic          pxclk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          line_start,
   input  logic [CW-1:0] lCensus,
   input  logic [CW-1:0] rCensus,
   output logic          out_valid,
   output logic [DW-1:0] disparity,
   output logic [HW-1:0] cost,
   output logic          uniq
);

   localparam int unsigned NDLY = MAX_DISP - 1;

   // Right-code delay line: dly_q[k] holds the right pixel k+1 columns back.
   logic [CW-1:0] dly_q [NDLY];

   // Column the next pixel takes unless it carries line_start.
   logic [DW-1:0] col_q;
   logic [DW-1:0] cur_col;
   logic [DW-1:0] col_d;

   logic [HW-1:0]       cost_now [MAX_DISP];
   logic [MAX_DISP-1:0] elig_now;

   // Stage 1: per-candidate costs and eligibility.
   logic                v1_q;
   logic [HW-1:0]       cost1_q [MAX_DISP];
   logic [MAX_DISP-1:0] elig1_q;

   // Stage 2: winner-take-all result.
   logic          v2_q;
   logic [DW-1:0] disp_q;
   logic [HW-1:0] cost_q;
   logic          uniq_q;

   logic [DW-1:0] disp_d;
   logic [HW-1:0] cost_d;
   logic          uniq_d;

   assign cur_col = line_start ? '0 : col_q;
   assign col_d   = (cur_col == DW'(MAX_DISP - 1)) ? cur_col : cur_col + DW'(1);

   // Candidate d pairs the left pixel with the right pixel at column x-d;
   // it is only meaningful once the line has advanced at least d columns.
   for (genvar d = 0; d < int'(MAX_DISP); d++) begin : g_cand
      logic [CW-1:0] cand;
      if (d == 0) begin : g_direct
         assign cand = rCensus;
      end else begin : g_delayed
         assign cand = dly_q[d-1];
      end

      hamming_cost #(
         .CW(CW),
         .HW(HW)
      ) u_ham (
         .a_i   (lCensus),
         .b_i   (cand),
         .cost_o(cost_now[d])
      );

      assign elig_now[d] = (cur_col >= DW'(d));
   end

   // Argmin and second-min over eligible candidates, scanned in ascending d.
   // Strict "<" keeps the smallest d on ties; a cost equal to the current
   // best falls through to second-best, giving a zero margin.
   always_comb begin
      logic have_best;
      logic have_second;
      logic [HW-1:0] second_cost;
      int margin;

      have_best   = 1'b0;
      have_second = 1'b0;
      disp_d      = '0;
      cost_d      = HW'(max_cost(CW));
      second_cost = HW'(max_cost(CW));
      for (int d = 0; d < int'(MAX_DISP); d++) begin
         if (elig1_q[d]) begin
            if (!have_best || (cost1_q[d] < cost_d)) begin
               if (have_best) begin
                  second_cost = cost_d;
                  have_second = 1'b1;
               end
               cost_d    = cost1_q[d];
               disp_d    = DW'(d);
               have_best = 1'b1;
            end else if (!have_second || (cost1_q[d] < second_cost)) begin
               second_cost = cost1_q[d];
               have_second = 1'b1;
            end
         end
      end
      margin = int'(second_cost) - int'(cost_d);
      uniq_d = have_second && (margin >= int'(UNIQ_TH));
   end

   // NOTE: non-blocking assignments for all registered state, so every register samples pre-edge values.
   always_ff @(posedge pxclk) begin
      if (reset) begin
         col_q   <= '0;
         // NOTE: the delay line is cleared on reset so a restarted line never matches stale right pixels.
         for (int k = 0; k < int'(NDLY); k++) begin
            dly_q[k] <= '0;
         end
         v1_q    <= 1'b0;
         elig1_q <= '0;
         for (int d = 0; d < int'(MAX_DISP); d++) begin
            cost1_q[d] <= '0;
         end
         v2_q    <= 1'b0;
         disp_q  <= '0;
         cost_q  <= '0;
         uniq_q  <= 1'b0;
      end else begin
         v1_q <= in_valid;
         v2_q <= v1_q;

         if (in_valid) begin
            col_q    <= col_d;
            dly_q[0] <= rCensus;
            for (int k = 1; k < int'(NDLY); k++) begin
               dly_q[k] <= dly_q[k-1];
            end
            elig1_q <= elig_now;
            for (int d = 0; d < int'(MAX_DISP); d++) begin
               cost1_q[d] <= cost_now[d];
            end
         end

         if (v1_q) begin
            disp_q <= disp_d;
            cost_q <= cost_d;
            uniq_q <= uniq_d;
         end
      end
   end

   assign out_valid = v2_q;
   assign disparity = disp_q;
   assign cost      = cost_q;
   assign uniq      = uniq_q;

endmodule : stereo_wta_n

// File: tb/tb_stereo_wta_n.sv
// ---------------------------------------------------------------------------
// tb_stereo_wta_n
// Directed bench for stereo_wta_n at CW=8, MAX_DISP=4, UNIQ_TH=1.
// Inputs change just after the falling edge; outputs are read at the next
// falling edge, so after driving step i the outputs reflect step i-1.
// ---------------------------------------------------------------------------
module tb_stereo_wta_n;

   logic       pxclk;
   logic       reset;
   logic       in_valid;
   logic       line_start;
   logic [7:0] lCensus;
   logic [7:0] rCensus;
   logic       out_valid;
   logic [1:0] disparity;
   logic [3:0] cost;
   logic       uniq;

   int checks;
   int errors;

   stereo_wta_n #(
      .CW      (8),
      .MAX_DISP(4),
      .UNIQ_TH (1)
   ) dut (
      .pxclk     (pxclk),
      .reset     (reset),
      .in_valid  (in_valid),
      .line_start(line_start),
      .lCensus   (lCensus),
      .rCensus   (rCensus),
      .out_valid (out_valid),
      .disparity (disparity),
      .cost      (cost),
      .uniq      (uniq)
   );

   initial begin
      pxclk = 1'b0;
      forever #5 pxclk = ~pxclk;
   end

   task automatic drive(input logic rst, input logic vld, input logic ls,
                        input logic [7:0] l, input logic [7:0] r);
      reset      = rst;
      in_valid   = vld;
      line_start = ls;
      lCensus    = l;
      rCensus    = r;
      @(posedge pxclk);
      @(negedge pxclk);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   // Reset held 5 cycles with valid pixels present, then one pixel.
   task automatic test_reset();
      bit         rs [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
      bit         vv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic [7:0] lv [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
      logic [7:0] rv [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
      int ev [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      int ec [8] = '{0, 0, 0, 0, 0, 0, 8, 8};
      for (int i = 0; i < 8; i++) begin
         drive(rs[i], vv[i], 1'b0, lv[i], rv[i]);
         checks++;
         if ({out_valid, disparity, cost, uniq} !== {ev[i][0], 2'd0, ec[i][3:0], 1'b0}) begin
            errors++;
            $display("FAIL reset step %0d: got v=%0b d=%0d c=%0d u=%0b, expected v=%0d d=0 c=%0d u=0",
                     i, out_valid, disparity, cost, uniq, ev[i], ec[i]);
         end
      end
   endtask

   // lCensus[x] = rCensus[x-2]: disparity 2 once the line reaches column 2.
   task automatic test_match();
      bit         sv [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
      bit         vv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic [7:0] lv [8] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00};
      logic [7:0] rv [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h00, 8'h00};
      int ev [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
      int ed [8] = '{0, 0, 0, 2, 2, 2, 2, 2};
      int ec [8] = '{0, 1, 1, 0, 0, 0, 0, 0};
      int eu [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, vv[i], sv[i], lv[i], rv[i]);
         checks++;
         if ({out_valid, disparity, cost, uniq} !== {ev[i][0], ed[i][1:0], ec[i][3:0], eu[i][0]}) begin
            errors++;
            $display("FAIL match step %0d: got v=%0b d=%0d c=%0d u=%0b, expected v=%0d d=%0d c=%0d u=%0d",
                     i, out_valid, disparity, cost, uniq, ev[i], ed[i], ec[i], eu[i]);
         end
      end
   endtask

   // All-zero codes: every candidate ties at cost 0, smallest d wins.
   task automatic test_all_zero();
      bit sv [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
      bit vv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      int ev [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, vv[i], sv[i], 8'h00, 8'h00);
         checks++;
         if ({out_valid, disparity, cost, uniq} !== {ev[i][0], 2'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL all_zero step %0d: got v=%0b d=%0d c=%0d u=%0b, expected v=%0d d=0 c=0 u=0",
                     i, out_valid, disparity, cost, uniq, ev[i]);
         end
      end
   endtask

   // A second line starts with perfect matches waiting in the delay line
   // at d>=1; they must be ignored at column 0 and d>=2 at column 1.
   task automatic test_eligibility();
      bit         sv [6] = '{1, 0, 1, 0, 0, 0};
      bit         vv [6] = '{1, 1, 1, 1, 0, 0};
      logic [7:0] lv [6] = '{8'h00, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'h00};
      logic [7:0] rv [6] = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
      int ev [6] = '{0, 1, 1, 1, 1, 0};
      int ed [6] = '{0, 0, 0, 0, 1, 1};
      int ec [6] = '{0, 8, 8, 8, 7, 7};
      int eu [6] = '{0, 0, 0, 0, 1, 1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, vv[i], sv[i], lv[i], rv[i]);
         checks++;
         if ({out_valid, disparity, cost, uniq} !== {ev[i][0], ed[i][1:0], ec[i][3:0], eu[i][0]}) begin
            errors++;
            $display("FAIL eligibility step %0d: got v=%0b d=%0d c=%0d u=%0b, expected v=%0d d=%0d c=%0d u=%0d",
                     i, out_valid, disparity, cost, uniq, ev[i], ed[i], ec[i], eu[i]);
         end
      end
   endtask

   // Match scenario with a bubble after every pixel; the bubbles carry
   // junk codes and line_start, which must be ignored.
   task automatic test_bubbles();
      bit         sv [13] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
      bit         vv [13] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
      logic [7:0] lv [13] = '{8'h00, 8'hAA, 8'h00, 8'hAA, 8'h01, 8'hAA, 8'h02,
                              8'hAA, 8'h04, 8'hAA, 8'h08, 8'hAA, 8'hAA};
      logic [7:0] rv [13] = '{8'h01, 8'h55, 8'h02, 8'h55, 8'h04, 8'h55, 8'h08,
                              8'h55, 8'h10, 8'h55, 8'h20, 8'h55, 8'h55};
      int ev [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
      int ed [13] = '{0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 2, 2, 2};
      int ec [13] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      int eu [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(1'b0, vv[i], sv[i], lv[i], rv[i]);
         checks++;
         if ({out_valid, disparity, cost, uniq} !== {ev[i][0], ed[i][1:0], ec[i][3:0], eu[i][0]}) begin
            errors++;
            $display("FAIL bubbles step %0d: got v=%0b d=%0d c=%0d u=%0b, expected v=%0d d=%0d c=%0d u=%0d",
                     i, out_valid, disparity, cost, uniq, ev[i], ed[i], ec[i], eu[i]);
         end
      end
   endtask

   // One-cycle reset at column 3 discards pixels in flight; the line then
   // resumes without line_start and restarts at column 0 on a clean delay line.
   task automatic test_reset_midline();
      bit         rs [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
      bit         sv [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
      bit         vv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic [7:0] lv [8] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00};
      logic [7:0] rv [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h00, 8'h00};
      int ev [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
      int ec [8] = '{0, 1, 1, 0, 0, 2, 2, 2};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(rs[i], vv[i], sv[i], lv[i], rv[i]);
         checks++;
         if ({out_valid, disparity, cost, uniq} !== {ev[i][0], 2'd0, ec[i][3:0], 1'b0}) begin
            errors++;
            $display("FAIL reset_midline step %0d: got v=%0b d=%0d c=%0d u=%0b, expected v=%0d d=0 c=%0d u=0",
                     i, out_valid, disparity, cost, uniq, ev[i], ec[i]);
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      line_start = 1'b0;
      lCensus    = 8'h00;
      rCensus    = 8'h00;
      @(negedge pxclk);

      test_reset();
      test_match();
      test_all_zero();
      test_eligibility();
      test_bubbles();
      test_reset_midline();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_stereo_wta_n
